ipdc_window_core: RTL and testbench



---
 rtl/ipdc_pkg.sv | 33 +++
 rtl/ipdc_window_core_if.sv | 28 ++
 rtl/ipdc_img_buf.sv | 26 ++
 rtl/ipdc_window_core.sv | 214 +++++++++++++++++++++
 tb/tb_ipdc_window_core.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/ipdc_pkg.sv
// ipdc_pkg: shared definitions for the windowed image display core.
//   - opcode encodings accepted on i_op_mode
//   - FSM state type for the core controller
//   - ipdc_clog2: ceil(log2(v)), never below 1, for sizing counters
package ipdc_pkg;

  localparam logic [3:0] OP_LOAD     = 4'd0;
  localparam logic [3:0] OP_RIGHT    = 4'd1;
  localparam logic [3:0] OP_LEFT     = 4'd2;
  localparam logic [3:0] OP_UP       = 4'd3;
  localparam logic [3:0] OP_DOWN     = 4'd4;
  localparam logic [3:0] OP_REDUCE   = 4'd5;
  localparam logic [3:0] OP_INCREASE = 4'd6;
  localparam logic [3:0] OP_DISPLAY  = 4'd7;
  localparam logic [3:0] OP_CH_SUM   = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READY,
    S_WAIT,
    S_LOAD,
    S_DISP,
    S_SUM
  } ipdc_state_e;

  function automatic int unsigned ipdc_clog2(input int unsigned v);
    int unsigned w;
    w = 0;
    while ((64'd1 << w) < 64'(v)) w++;
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/ipdc_window_core_if.sv
// ipdc_window_core_if: opcode and pixel-data handshake bundle.
//   i_op_valid/i_op_mode/o_op_ready : opcode handshake
//   i_in_valid/i_in_data/o_in_ready : image load stream
//   o_out_valid/o_out_data          : result stream (OW bits, zero-extended)
// master = command/data source, slave = the core.
interface ipdc_window_core_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned OW = 14
);
  logic          i_op_valid;
  logic [3:0]    i_op_mode;
  logic          o_op_ready;
  logic          i_in_valid;
  logic [DW-1:0] i_in_data;
  logic          o_in_ready;
  logic          o_out_valid;
  logic [OW-1:0] o_out_data;

  modport master (
    output i_op_valid, i_op_mode, i_in_valid, i_in_data,
    input  o_op_ready, o_in_ready, o_out_valid, o_out_data
  );

  modport slave (
    input  i_op_valid, i_op_mode, i_in_valid, i_in_data,
    output o_op_ready, o_in_ready, o_out_valid, o_out_data
  );
endinterface

// File: rtl/ipdc_img_buf.sv
// ipdc_img_buf: single-port synchronous image store, no reset.
//   i_clk   : clock
//   i_we    : write enable (writes i_wdata at i_addr)
//   i_addr  : word address
//   i_wdata : write data
//   o_rdata : word at i_addr, one cycle after the address is presented
module ipdc_img_buf #(
  parameter int unsigned DEPTH = 2048,
  parameter int unsigned AW    = 11,
  parameter int unsigned DW    = 8
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/ipdc_window_core.sv
// ipdc_window_core: buffers an IMG_DIM x IMG_DIM x CH_MAX image and executes
// one opcode at a time: load, origin shift, depth change, windowed display
// and per-pixel channel sum over the display window.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   bus     : opcode / load / result handshake (slave side)
module ipdc_window_core
  import ipdc_pkg::*;
#(
  parameter int unsigned IMG_DIM = 8,
  parameter int unsigned CH_MAX  = 32,
  parameter int unsigned CH_MIN  = 8,
  parameter int unsigned WIN     = 2,
  parameter int unsigned DW      = 8,
  parameter int unsigned OW      = 14
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  ipdc_window_core_if.slave    bus
);

  localparam int unsigned NPIX  = IMG_DIM * IMG_DIM;
  localparam int unsigned TOTAL = NPIX * CH_MAX;
  localparam int unsigned AW    = ipdc_clog2(TOTAL);
  localparam int unsigned XW    = ipdc_clog2(IMG_DIM);
  localparam int unsigned CW    = ipdc_clog2(CH_MAX);
  localparam int unsigned WW    = ipdc_clog2(WIN);
  localparam int unsigned OMAX  = IMG_DIM - WIN;

  localparam logic [CW:0]   DEP_MAX = (CW+1)'(CH_MAX);
  localparam logic [CW:0]   DEP_MIN = (CW+1)'(CH_MIN);
  localparam logic [XW-1:0] ORG_MAX = XW'(OMAX);
  localparam logic [WW-1:0] WIN_END = WW'(WIN - 1);
  localparam logic [AW-1:0] LD_END  = AW'(TOTAL - 1);

  if (OW < DW + ipdc_clog2(CH_MAX + 1)) begin : g_ow_check
    $error("ipdc_window_core: OW too narrow for a full-depth channel sum");
  end

  ipdc_state_e   r_state;
  logic [XW-1:0] r_ox, r_oy;
  logic [CW:0]   r_depth;
  logic [AW-1:0] r_ld_cnt;
  logic [CW-1:0] r_c;
  logic [WW-1:0] r_wx, r_wy;
  logic          r_issue_done;
  logic          r_rd_vld, r_rd_first, r_rd_last;
  logic [OW-1:0] r_acc;
  logic          r_op_ready, r_in_ready, r_out_valid;
  logic [OW-1:0] r_out_data;

  logic          w_c_last, w_wx_last, w_wy_last, w_win_last;
  logic          w_issue, w_ld_fire;
  logic [WW-1:0] w_wx_nxt, w_wy_nxt;
  logic [CW-1:0] w_c_nxt;
  logic [XW-1:0] w_row, w_col;
  logic [AW-1:0] w_rd_addr, w_mem_addr;
  logic [DW-1:0] w_mem_q;
  logic [OW-1:0] w_acc_next;

  always_comb begin
    w_c_last   = ({1'b0, r_c} == (r_depth - (CW+1)'(1)));
    w_wx_last  = (r_wx == WIN_END);
    w_wy_last  = (r_wy == WIN_END);
    w_win_last = w_wx_last & w_wy_last;
    w_c_nxt    = w_c_last ? '0 : r_c + CW'(1);
    w_wx_nxt   = w_wx_last ? '0 : r_wx + WW'(1);
    w_wy_nxt   = r_wy;
    if (w_wx_last) w_wy_nxt = w_wy_last ? '0 : r_wy + WW'(1);
    w_issue    = ((r_state == S_DISP) || (r_state == S_SUM)) && !r_issue_done;
    w_ld_fire  = (r_state == S_LOAD) && r_in_ready && bus.i_in_valid;
    w_row      = r_oy + XW'(r_wy);
    w_col      = r_ox + XW'(r_wx);
    w_rd_addr  = AW'(r_c) * AW'(NPIX) + AW'(w_row) * AW'(IMG_DIM) + AW'(w_col);
    // Load order is channel-major/row/column, so the load count is the address.
    w_mem_addr = (r_state == S_LOAD) ? r_ld_cnt : w_rd_addr;
    w_acc_next = (r_rd_first ? '0 : r_acc) + OW'(w_mem_q);
  end

  ipdc_img_buf #(
    .DEPTH (TOTAL),
    .AW    (AW),
    .DW    (DW)
  ) u_img_buf (
    .i_clk   (i_clk),
    .i_we    (w_ld_fire),
    .i_addr  (w_mem_addr),
    .i_wdata (bus.i_in_data),
    .o_rdata (w_mem_q)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_ox         <= '0;
      r_oy         <= '0;
      r_depth      <= DEP_MAX;
      r_ld_cnt     <= '0;
      r_c          <= '0;
      r_wx         <= '0;
      r_wy         <= '0;
      r_issue_done <= 1'b0;
      r_rd_vld     <= 1'b0;
      r_rd_first   <= 1'b0;
      r_rd_last    <= 1'b0;
      r_acc        <= '0;
      r_op_ready   <= 1'b0;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
    end else begin
      r_op_ready <= 1'b0;

      // Read pipeline shared by DISPLAY and CH_SUM: a display read is a
      // one-term sum, so first/last are forced high outside SUM.
      r_rd_vld    <= w_issue;
      r_rd_first  <= (r_state == S_SUM) ? (r_c == '0) : 1'b1;
      r_rd_last   <= (r_state == S_SUM) ? w_c_last : 1'b1;
      r_out_valid <= r_rd_vld & r_rd_last;
      if (r_rd_vld) begin
        r_acc <= w_acc_next;
        if (r_rd_last) r_out_data <= w_acc_next;
      end

      case (r_state)
        S_IDLE: begin
          r_state    <= S_READY;
          r_op_ready <= 1'b1;
        end

        S_READY: r_state <= S_WAIT;

        S_WAIT: begin
          if (bus.i_op_valid) begin
            r_state      <= S_READY;
            r_op_ready   <= 1'b1;
            r_ld_cnt     <= '0;
            r_c          <= '0;
            r_wx         <= '0;
            r_wy         <= '0;
            r_issue_done <= 1'b0;
            case (bus.i_op_mode)
              OP_LOAD: begin
                r_state    <= S_LOAD;
                r_op_ready <= 1'b0;
                r_in_ready <= 1'b1;
              end
              OP_DISPLAY: begin
                r_state    <= S_DISP;
                r_op_ready <= 1'b0;
              end
              OP_CH_SUM: begin
                r_state    <= S_SUM;
                r_op_ready <= 1'b0;
              end
              OP_RIGHT:    if (r_ox != ORG_MAX) r_ox <= r_ox + XW'(1);
              OP_LEFT:     if (r_ox != '0)      r_ox <= r_ox - XW'(1);
              OP_DOWN:     if (r_oy != ORG_MAX) r_oy <= r_oy + XW'(1);
              OP_UP:       if (r_oy != '0)      r_oy <= r_oy - XW'(1);
              OP_REDUCE:   if (r_depth > DEP_MIN) r_depth <= r_depth >> 1;
              OP_INCREASE: if (r_depth < DEP_MAX) r_depth <= r_depth << 1;
              default: ;
            endcase
          end
        end

        S_LOAD: begin
          if (w_ld_fire) begin
            if (r_ld_cnt == LD_END) begin
              r_in_ready <= 1'b0;
              r_state    <= S_READY;
              r_op_ready <= 1'b1;
            end else begin
              r_ld_cnt <= r_ld_cnt + AW'(1);
            end
          end
        end

        S_DISP, S_SUM: begin
          if (w_issue) begin
            if (r_state == S_DISP) begin
              // channel outer, window inner
              r_wx <= w_wx_nxt;
              r_wy <= w_wy_nxt;
              if (w_win_last) r_c <= w_c_nxt;
              if (w_win_last && w_c_last) r_issue_done <= 1'b1;
            end else begin
              // window outer, channel inner
              r_c <= w_c_nxt;
              if (w_c_last) begin
                r_wx <= w_wx_nxt;
                r_wy <= w_wy_nxt;
              end
              if (w_c_last && w_win_last) r_issue_done <= 1'b1;
            end
          end
          // Leave once the final result is on the output register.
          if (r_issue_done && !r_rd_vld) begin
            r_state    <= S_READY;
            r_op_ready <= 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_op_ready  = r_op_ready;
  assign bus.o_in_ready  = r_in_ready;
  assign bus.o_out_valid = r_out_valid;
  assign bus.o_out_data  = r_out_data;

endmodule

// File: tb/tb_ipdc_window_core.sv
`timescale 1ns/1ps
module tb_ipdc_window_core;
  localparam int unsigned DIM = 8;
  localparam int unsigned CHM = 32;
  localparam int unsigned CHN = 8;
  localparam int unsigned WIN = 2;
  localparam int unsigned DW  = 8;
  localparam int unsigned OW  = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  int img [CHM][DIM][DIM];
  int m_ox, m_oy, m_dep;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ipdc_window_core_if #(.DW(DW), .OW(OW)) bus ();

  ipdc_window_core #(
    .IMG_DIM (DIM),
    .CH_MAX  (CHM),
    .CH_MIN  (CHN),
    .WIN     (WIN),
    .DW      (DW),
    .OW      (OW)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.o_op_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (bus.o_op_ready !== 1'b1) chk("ready_timeout", bus.o_op_ready, 1);
  endtask

  // Issues one opcode; returns accept cycle n, leaves time at negedge of n+1.
  task automatic do_op(input logic [3:0] mode, output int n);
    wait_ready();
    repeat (1 + $urandom_range(0, 2)) @(negedge clk);
    bus.i_op_valid = 1'b1;
    bus.i_op_mode  = mode;
    n = cyc;
    @(negedge clk);
    bus.i_op_valid = 1'b0;
    bus.i_op_mode  = 4'($urandom);
  endtask

  function automatic void model_op(input logic [3:0] mode);
    case (mode)
      4'd1: if (m_ox < DIM - WIN) m_ox++;
      4'd2: if (m_ox > 0) m_ox--;
      4'd3: if (m_oy > 0) m_oy--;
      4'd4: if (m_oy < DIM - WIN) m_oy++;
      4'd5: if (m_dep > CHN) m_dep = m_dep / 2;
      4'd6: if (m_dep < CHM) m_dep = m_dep * 2;
      default: ;
    endcase
  endfunction

  task automatic collect(input bit is_sum, input int n);
    int got[$];
    int exp[$];
    int first = -1, last = -1, rdy = -1;
    if (!is_sum) begin
      for (int c = 0; c < m_dep; c++)
        for (int dy = 0; dy < WIN; dy++)
          for (int dx = 0; dx < WIN; dx++)
            exp.push_back(img[c][m_oy+dy][m_ox+dx]);
    end else begin
      for (int dy = 0; dy < WIN; dy++)
        for (int dx = 0; dx < WIN; dx++) begin
          int s = 0;
          for (int c = 0; c < m_dep; c++) s += img[c][m_oy+dy][m_ox+dx];
          exp.push_back(s);
        end
    end
    for (int i = 0; i < 400; i++) begin
      if (bus.o_out_valid === 1'b1) begin
        got.push_back(int'(bus.o_out_data));
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (bus.o_op_ready === 1'b1) begin
        rdy = cyc;
        break;
      end
      @(negedge clk);
    end
    chk(is_sum ? "sum_done_seen" : "disp_done_seen", 32'(rdy >= 0), 1);
    chk(is_sum ? "sum_count" : "disp_count", got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (i < got.size()) chk(is_sum ? "sum_value" : "disp_value", got[i], exp[i]);
    chk(is_sum ? "sum_ready_lat" : "disp_ready_lat", rdy - last, 1);
    if (!is_sum) begin
      chk("disp_first_lat", first - n, 3);
      chk("disp_contiguous", last - first + 1, got.size());
    end else begin
      chk("sum_ready_bound", 32'(rdy <= n + WIN*WIN*(m_dep+2) + 4), 1);
    end
  endtask

  task automatic run_op(input logic [3:0] mode);
    int n;
    do_op(mode, n);
    if (mode == 4'd7) collect(1'b0, n);
    else if (mode == 4'd11) collect(1'b1, n);
    else begin
      chk("op_ready_next", bus.o_op_ready, 1);
      chk("no_out_valid", bus.o_out_valid, 0);
      model_op(mode);
    end
  endtask

  task automatic load_img(input bit rnd);
    int n;
    do_op(4'd0, n);
    chk("in_ready_n1", bus.o_in_ready, 1);
    for (int c = 0; c < CHM; c++)
      for (int y = 0; y < DIM; y++)
        for (int x = 0; x < DIM; x++) begin
          int d;
          while ($urandom_range(0, 3) == 0) begin
            bus.i_in_valid = 1'b0;
            bus.i_in_data  = 8'($urandom);
            @(negedge clk);
          end
          d = rnd ? int'($urandom_range(0, 255)) : (c*64 + y*8 + x) % 256;
          img[c][y][x] = d;
          bus.i_in_valid = 1'b1;
          bus.i_in_data  = 8'(d);
          @(negedge clk);
        end
    bus.i_in_valid = 1'b0;
    chk("in_ready_drop", bus.o_in_ready, 0);
    chk("load_ready", bus.o_op_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.i_op_valid = 1'b0;
    bus.i_op_mode  = '0;
    bus.i_in_valid = 1'b0;
    bus.i_in_data  = '0;
    m_ox = 0; m_oy = 0; m_dep = CHM;
    repeat (2) @(negedge clk);
    chk("rst_op_ready", bus.o_op_ready, 0);
    chk("rst_in_ready", bus.o_in_ready, 0);
    chk("rst_out_valid", bus.o_out_valid, 0);
    chk("rst_out_data", bus.o_out_data, 0);
    rst_n = 1'b1;

    // Patterned load with gaps, then the directed display/sum scenarios.
    load_img(1'b0);
    run_op(4'd7);
    repeat (7) run_op(4'd1);
    repeat (3) run_op(4'd5);
    run_op(4'd7);
    repeat (7) run_op(4'd2);
    repeat (3) run_op(4'd6);
    repeat (7) run_op(4'd4);
    run_op(4'd3);
    run_op(4'd7);
    repeat (7) run_op(4'd3);
    repeat (2) run_op(4'd5);
    run_op(4'd11);
    run_op(4'd12);
    repeat (3) run_op(4'd6);
    run_op(4'd11);

    // Random image and random opcode stream; load-side noise must be ignored.
    load_img(1'b1);
    for (int k = 0; k < 24; k++) begin
      logic [3:0] m;
      case ($urandom_range(0, 9))
        0: m = 4'd1;  1: m = 4'd2;  2: m = 4'd3;  3: m = 4'd4;
        4: m = 4'd5;  5: m = 4'd6;  6: m = 4'd7;  7: m = 4'd11;
        8: m = 4'd11;
        default: m = 4'(8 + $urandom_range(0, 7));
      endcase
      if (m == 4'd0 || m == 4'd11 && k % 5 == 4) m = 4'd7;
      bus.i_in_valid = 1'($urandom_range(0, 1));
      bus.i_in_data  = 8'($urandom);
      run_op(m);
    end
    bus.i_in_valid = 1'b0;
    run_op(4'd7);

    // Reset in the middle of a display.
    run_op(4'd1);
    run_op(4'd4);
    run_op(4'd5);
    do_op(4'd7, n);
    repeat (4) @(negedge clk);
    chk("disp_active_pre_rst", bus.o_out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", bus.o_out_valid, 0);
    chk("async_rst_out_data", bus.o_out_data, 0);
    chk("async_rst_op_ready", bus.o_op_ready, 0);
    m_ox = 0; m_oy = 0; m_dep = CHM;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", bus.o_op_ready, 1);
    run_op(4'd11);
    run_op(4'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
